// File: rtl/seq_shift_register_pkg.sv
// Shared op-codes, state encodings and small helpers for the sequenced shift register.
package seq_shift_register_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP   = 3'd0;
    localparam op_t OP_SHL   = 3'd1;
    localparam op_t OP_SHR   = 3'd2;
    localparam op_t OP_ROL   = 3'd3;
    localparam op_t OP_ROR   = 3'd4;
    localparam op_t OP_ASR   = 3'd5;
    localparam op_t OP_LOAD  = 3'd6;
    localparam op_t OP_CLEAR = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Ops that move bits and therefore need the multi-cycle stepper.
    function automatic logic is_shift_op(input op_t op);
        return (op != OP_NOP) && (op != OP_LOAD) && (op != OP_CLEAR);
    endfunction

    // Four-input mux used per bit by the step unit.
    function automatic logic mux4(input logic [3:0] d, input logic [1:0] s);
        return d[s];
    endfunction

endpackage

// File: rtl/seq_shift_register_if.sv
// Request/status bundle between a requester and the shift register.
interface seq_shift_register_if
    import seq_shift_register_pkg::*;
#(
    parameter int unsigned N = 16
) ();
    localparam int unsigned AW = $clog2(N + 1);

    logic          start;
    op_t           op;
    logic [AW-1:0] amount;
    logic [N-1:0]  load_data;
    logic          ser_in;
    logic [N-1:0]  q;
    logic          ser_out;
    logic          busy;
    logic          done;

    modport master (
        output start, op, amount, load_data, ser_in,
        input  q, ser_out, busy, done
    );

    modport slave (
        input  start, op, amount, load_data, ser_in,
        output q, ser_out, busy, done
    );
endinterface

// File: rtl/seq_shift_register_step_unit.sv
// Combinational single-step shifter: next word and the departing bit for one op.
module seq_shift_register_step_unit
    import seq_shift_register_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] q_i,
    input  op_t          op_i,
    input  logic         ser_i,
    output logic [N-1:0] q_next_c_o,
    output logic         bit_out_c_o
);
    // sel: 0 = take lower neighbour (left move), 1 = upper neighbour (right move), 2 = hold
    logic [1:0]   sel;
    logic         fill_lo;
    logic         fill_hi;
    logic [N-1:0] lo_src;
    logic [N-1:0] hi_src;

    // Direction, fill bits and departing bit per op.
    always_comb begin
        sel         = 2'd2;
        fill_lo     = ser_i;
        fill_hi     = ser_i;
        bit_out_c_o = 1'b0;
        case (op_i)
            OP_SHL: begin sel = 2'd0; bit_out_c_o = q_i[N-1]; end
            OP_ROL: begin sel = 2'd0; fill_lo = q_i[N-1]; bit_out_c_o = q_i[N-1]; end
            OP_SHR: begin sel = 2'd1; bit_out_c_o = q_i[0]; end
            OP_ROR: begin sel = 2'd1; fill_hi = q_i[0]; bit_out_c_o = q_i[0]; end
            OP_ASR: begin sel = 2'd1; fill_hi = q_i[N-1]; bit_out_c_o = q_i[0]; end
            default: ;
        endcase
    end

    assign lo_src = {q_i[N-2:0], fill_lo};
    assign hi_src = {fill_hi, q_i[N-1:1]};

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign q_next_c_o[i] = mux4({1'b0, q_i[i], hi_src[i], lo_src[i]}, sel);
    end

endmodule

// File: rtl/seq_shift_register.sv
// Universal shift register with a multi-step sequencer and busy/done handshake.
module seq_shift_register
    import seq_shift_register_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_shift_register_if.slave  bus
);
    localparam int unsigned AW = $clog2(N + 1);

    logic [1:0]    state_q,   state_d;
    logic [AW-1:0] count_q,   count_d;
    op_t           op_q,      op_d;
    logic [N-1:0]  q_q,       q_d;
    logic          ser_out_q, ser_out_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;

    logic [N-1:0]  step_q;
    logic          step_bit;

    seq_shift_register_step_unit #(.N(N)) u_step (
        .q_i         (q_q),
        .op_i        (op_q),
        .ser_i       (bus.ser_in),
        .q_next_c_o  (step_q),
        .bit_out_c_o (step_bit)
    );

    // Next-state: accept in IDLE/DONE, one step per cycle in SHIFT.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        q_d       = q_q;
        ser_out_d = ser_out_q;

        case (state_q)
            ST_SHIFT: begin
                q_d       = step_q;
                ser_out_d = step_bit;
                count_d   = count_q - AW'(1);
                if (count_q == AW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    if (!is_shift_op(bus.op) || (bus.amount == '0)) begin
                        if (bus.op == OP_LOAD) begin
                            q_d = bus.load_data;
                        end else if (bus.op == OP_CLEAR) begin
                            q_d = '0;
                        end
                        state_d = ST_DONE;
                    end else begin
                        op_d    = bus.op;
                        count_d = (bus.amount > AW'(N)) ? AW'(N) : bus.amount;
                        state_d = ST_SHIFT;
                    end
                end
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            op_q      <= OP_NOP;
            q_q       <= '0;
            ser_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            q_q       <= q_d;
            ser_out_q <= ser_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.ser_out = ser_out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_shift_register.sv
// Directed bench for seq_shift_register at N=8.
module tb_seq_shift_register;
    import seq_shift_register_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int nb;
    logic seen;

    seq_shift_register_if #(.N(8)) bus ();

    seq_shift_register #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request at a falling edge; returns one falling edge after acceptance.
    task automatic issue(input op_t op_v, input logic [3:0] amt_v, input logic [7:0] data_v,
                         input logic ser_v);
        bus.start     = 1'b1;
        bus.op        = op_v;
        bus.amount    = amt_v;
        bus.load_data = data_v;
        bus.ser_in    = ser_v;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.op = OP_NOP; bus.amount = '0; bus.load_data = '0; bus.ser_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_q",       32'(bus.q),       32'h0);
        check("rst_ser_out", 32'(bus.ser_out), 32'h0);
        check("rst_busy",    32'(bus.busy),    32'h0);
        check("rst_done",    32'(bus.done),    32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1. LOAD A5 with amount 0
        issue(OP_LOAD, 4'd0, 8'hA5, 1'b0);
        check("load_q",     32'(bus.q),    32'hA5);
        check("load_done",  32'(bus.done), 32'h1);
        check("load_busy",  32'(bus.busy), 32'h0);
        @(negedge clk);
        check("load_done_end", 32'(bus.done), 32'h0);
        check("load_busy_end", 32'(bus.busy), 32'h0);

        // 2. SHL by 3 filling ones
        issue(OP_SHL, 4'd3, 8'h00, 1'b1);
        check("shl_busy0", 32'(bus.busy), 32'h1);
        check("shl_q0",    32'(bus.q),    32'hA5);
        @(negedge clk);
        check("shl_q1",   32'(bus.q),       32'h4B);
        check("shl_so1",  32'(bus.ser_out), 32'h1);
        check("shl_busy1",32'(bus.busy),    32'h1);
        @(negedge clk);
        check("shl_q2",   32'(bus.q),       32'h97);
        check("shl_so2",  32'(bus.ser_out), 32'h0);
        check("shl_busy2",32'(bus.busy),    32'h1);
        @(negedge clk);
        check("shl_q3",   32'(bus.q),       32'h2F);
        check("shl_so3",  32'(bus.ser_out), 32'h1);
        check("shl_busy3",32'(bus.busy),    32'h0);
        check("shl_done", 32'(bus.done),    32'h1);
        @(negedge clk);
        check("shl_done_end", 32'(bus.done), 32'h0);

        // 3a. ASR by 2 from 81
        issue(OP_LOAD, 4'd0, 8'h81, 1'b0);
        @(negedge clk);
        issue(OP_ASR, 4'd2, 8'h00, 1'b0);
        @(negedge clk);
        check("asr_q1",  32'(bus.q),       32'hC0);
        check("asr_so1", 32'(bus.ser_out), 32'h1);
        @(negedge clk);
        check("asr_q2",  32'(bus.q),       32'hE0);
        check("asr_so2", 32'(bus.ser_out), 32'h0);
        check("asr_done",32'(bus.done),    32'h1);
        @(negedge clk);

        // 3b. ROR by 9 clamps to 8 and restores the word
        issue(OP_LOAD, 4'd0, 8'h81, 1'b0);
        @(negedge clk);
        issue(OP_ROR, 4'd9, 8'h00, 1'b0);
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) nb++;
            @(negedge clk);
        end
        check("ror_done_seen",   32'(seen),        32'h1);
        check("ror_busy_cycles", 32'(nb),          32'd8);
        check("ror_q",           32'(bus.q),       32'h81);
        check("ror_so",          32'(bus.ser_out), 32'h1);
        @(negedge clk);

        // 4. start during SHIFT ignored; start in DONE accepted without gap
        issue(OP_LOAD, 4'd0, 8'h81, 1'b0);
        @(negedge clk);
        issue(OP_SHL, 4'd2, 8'h00, 1'b0);
        bus.start = 1'b1; bus.op = OP_CLEAR; bus.amount = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_q1", 32'(bus.q), 32'h02);
        @(negedge clk);
        check("ign_q2",    32'(bus.q),    32'h04);
        check("ign_done",  32'(bus.done), 32'h1);
        issue(OP_LOAD, 4'd0, 8'h3C, 1'b0);
        check("b2b_q",    32'(bus.q),    32'h3C);
        check("b2b_done", 32'(bus.done), 32'h1);
        check("b2b_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        check("b2b_done_end", 32'(bus.done), 32'h0);

        // 5. reset mid-SHIFT after 2 of 5 steps
        issue(OP_LOAD, 4'd0, 8'hFF, 1'b0);
        @(negedge clk);
        issue(OP_SHR, 4'd5, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_q", 32'(bus.q), 32'h3F);
        rst = 1'b1;
        #1;
        check("mid_rst_q",    32'(bus.q),       32'h0);
        check("mid_rst_busy", 32'(bus.busy),    32'h0);
        check("mid_rst_done", 32'(bus.done),    32'h0);
        check("mid_rst_so",   32'(bus.ser_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done || bus.busy) seen = 1'b1;
            @(negedge clk);
        end
        check("post_rst_quiet", 32'(seen), 32'h0);
        issue(OP_SHL, 4'd1, 8'h00, 1'b1);
        check("post_rst_busy", 32'(bus.busy), 32'h1);
        @(negedge clk);
        check("post_rst_q",    32'(bus.q),       32'h01);
        check("post_rst_so",   32'(bus.ser_out), 32'h0);
        check("post_rst_done", 32'(bus.done),    32'h1);

        // 6. CLEAR, NOP and zero-amount shift keep ser_out
        issue(OP_LOAD, 4'd0, 8'hFF, 1'b0);
        @(negedge clk);
        issue(OP_SHL, 4'd1, 8'h00, 1'b0);
        @(negedge clk);
        check("pre_clr_q",  32'(bus.q),       32'hFE);
        check("pre_clr_so", 32'(bus.ser_out), 32'h1);
        issue(OP_CLEAR, 4'd0, 8'h00, 1'b0);
        check("clr_q",    32'(bus.q),       32'h00);
        check("clr_done", 32'(bus.done),    32'h1);
        check("clr_so",   32'(bus.ser_out), 32'h1);
        @(negedge clk);
        issue(OP_LOAD, 4'd0, 8'h5A, 1'b0);
        issue(OP_NOP, 4'd3, 8'h00, 1'b0);
        check("nop_q",    32'(bus.q),       32'h5A);
        check("nop_done", 32'(bus.done),    32'h1);
        check("nop_so",   32'(bus.ser_out), 32'h1);
        issue(OP_ROL, 4'd0, 8'h00, 1'b0);
        check("rol0_q",    32'(bus.q),    32'h5A);
        check("rol0_done", 32'(bus.done), 32'h1);
        check("rol0_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
